onfi_bus_seq: RTL

ONFI_BUS_SEQ -- requirements
Module: onfi_bus_seq

---
 rtl/onfi_pkg.sv | 38 +++
 rtl/onfi_rr_arb.sv | 28 ++
 rtl/onfi_bus_seq.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/onfi_pkg.sv
// Shared definitions for the ONFI command/address bus sequencer.
// Holds the FSM state encoding, the READ STATUS opcode, timing defaults
// and small helpers for address-byte selection and cycle-count clamping.
package onfi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CMD_LO  = 3'd1,
      ST_CMD_HI  = 3'd2,
      ST_ADDR_LO = 3'd3,
      ST_ADDR_HI = 3'd4,
      ST_WAIT    = 3'd5,
      ST_DATA    = 3'd6
   } onfi_state_e;

   localparam logic [7:0] ONFI_CMD_READ_STATUS = 8'h70;
   localparam int         ONFI_TWHR_DEF        = 6;
   localparam int         ONFI_TIMEOUT_DEF     = 1024;

   // At most five address cycles exist on the bus; 6 and 7 collapse to 5.
   function automatic logic [2:0] clamp_naddr(input logic [2:0] n);
      return (n > 3'd5) ? 3'd5 : n;
   endfunction

   // Address bytes go out LSB first; the 32-bit address has no byte 4,
   // so that cycle carries zero.
   function automatic logic [7:0] addr_byte(input logic [31:0] addr,
                                            input logic [2:0]  idx);
      case (idx)
         3'd0:    return addr[7:0];
         3'd1:    return addr[15:8];
         3'd2:    return addr[23:16];
         3'd3:    return addr[31:24];
         default: return 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/onfi_rr_arb.sv
// Two-way round-robin arbiter. Grant is combinational from req and the
// priority pointer; the pointer moves past the winner when upd is high
// and a grant is issued. After reset requester 0 has priority.
module onfi_rr_arb (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       upd,
   output logic [1:0] grant
);

   // prio = index of the requester that wins a tie
   logic prio;

   // Resolve a tie with the pointer; a single request wins outright.
   always_comb begin
      grant = 2'b00;
      if (req == 2'b11) grant = prio ? 2'b10 : 2'b01;
      else              grant = req;
   end

   // Hand priority to the requester that was not just served.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                        prio <= 1'b0;
      else if (upd && grant != 2'b00) prio <= grant[0];
   end

endmodule

// File: rtl/onfi_bus_seq.sv
// ONFI command/address bus sequencer for two requesters (status poller,
// page engine). Arbitrates, drives CMD / ADDR latch cycles, waits tWHR,
// then holds the data phase until the owner releases.
// Valid/ready: reqN is a level sampled only in IDLE; a request dropped
// before that sample is lost; gnt (one-hot) marks the owner from CMD_LO
// through DATA; the owner's relN is honoured only in DATA; done pulses
// one cycle on normal completion.
// Optional macro ONFI_SEQ_TIMEOUT_EN adds a data-phase watchdog that
// pulses err and returns to IDLE after TIMEOUT_CYC cycles in DATA.
module onfi_bus_seq
   import onfi_pkg::*;
#(
   parameter int TWHR_CYC    = ONFI_TWHR_DEF,
   parameter int TIMEOUT_CYC = ONFI_TIMEOUT_DEF
) (
   input  logic        onfi_clk,
   input  logic        onfi_rst,
   input  logic        r0_req,
   input  logic [7:0]  r0_cmd,
   input  logic [31:0] r0_addr,
   input  logic [2:0]  r0_naddr,
   input  logic        r0_rel,
   input  logic        r1_req,
   input  logic [7:0]  r1_cmd,
   input  logic [31:0] r1_addr,
   input  logic [2:0]  r1_naddr,
   input  logic        r1_rel,
   output logic [1:0]  gnt,
   output logic        data_ph,
   output logic [1:0]  done,
   output logic        onfi_cen,
   output logic        onfi_cle,
   output logic        onfi_ale,
   output logic        onfi_wen,
   output logic [7:0]  onfi_dq_o,
   output logic        onfi_dq_en,
   output logic        err,
   output onfi_state_e dbg_state
);

   localparam int CNT_MAX = (TIMEOUT_CYC > TWHR_CYC) ? TIMEOUT_CYC : TWHR_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   onfi_state_e      state;
   logic             owner;
   logic [31:0]      addr_q;
   logic [2:0]       naddr_q;
   logic [2:0]       idx;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       grant;
   logic [7:0]       sel_cmd;
   logic [31:0]      sel_addr;
   logic [2:0]       sel_naddr;
   logic             owner_rel;

   assign dbg_state = state;

   onfi_rr_arb u_arb (
      .clk   (onfi_clk),
      .rst   (onfi_rst),
      .req   ({r1_req, r0_req}),
      .upd   (state == ST_IDLE),
      .grant (grant)
   );

   // Select the winning requester's transaction fields and the owner's release.
   always_comb begin
      sel_cmd   = grant[1] ? r1_cmd   : r0_cmd;
      sel_addr  = grant[1] ? r1_addr  : r0_addr;
      sel_naddr = grant[1] ? r1_naddr : r0_naddr;
      owner_rel = owner ? r1_rel : r0_rel;
   end

`ifndef ONFI_SEQ_TIMEOUT_EN
   assign err = 1'b0;
`endif

   // Bus sequencing FSM; every bus pin is registered here.
   always_ff @(posedge onfi_clk or posedge onfi_rst) begin
      if (onfi_rst) begin
         state      <= ST_IDLE;
         owner      <= 1'b0;
         addr_q     <= '0;
         naddr_q    <= '0;
         idx        <= '0;
         cnt        <= '0;
         gnt        <= 2'b00;
         data_ph    <= 1'b0;
         done       <= 2'b00;
         onfi_cen   <= 1'b1;
         onfi_cle   <= 1'b0;
         onfi_ale   <= 1'b0;
         onfi_wen   <= 1'b1;
         onfi_dq_o  <= 8'h00;
         onfi_dq_en <= 1'b0;
`ifdef ONFI_SEQ_TIMEOUT_EN
         err        <= 1'b0;
`endif
      end else begin
         done <= 2'b00;
`ifdef ONFI_SEQ_TIMEOUT_EN
         err  <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               if (grant != 2'b00) begin
                  owner      <= grant[1];
                  addr_q     <= sel_addr;
                  naddr_q    <= clamp_naddr(sel_naddr);
                  gnt        <= grant;
                  onfi_cen   <= 1'b0;
                  onfi_cle   <= 1'b1;
                  onfi_wen   <= 1'b0;
                  onfi_dq_o  <= sel_cmd;
                  onfi_dq_en <= 1'b1;
                  state      <= ST_CMD_LO;
               end
            end
            ST_CMD_LO: begin
               onfi_wen <= 1'b1;
               state    <= ST_CMD_HI;
            end
            ST_CMD_HI: begin
               onfi_cle <= 1'b0;
               if (naddr_q != 3'd0) begin
                  onfi_ale  <= 1'b1;
                  onfi_wen  <= 1'b0;
                  idx       <= 3'd0;
                  onfi_dq_o <= addr_byte(addr_q, 3'd0);
                  state     <= ST_ADDR_LO;
               end else begin
                  onfi_dq_en <= 1'b0;
                  onfi_dq_o  <= 8'h00;
                  cnt        <= '0;
                  state      <= ST_WAIT;
               end
            end
            ST_ADDR_LO: begin
               onfi_wen <= 1'b1;
               state    <= ST_ADDR_HI;
            end
            ST_ADDR_HI: begin
               if (idx == naddr_q - 3'd1) begin
                  onfi_ale   <= 1'b0;
                  onfi_dq_en <= 1'b0;
                  onfi_dq_o  <= 8'h00;
                  cnt        <= '0;
                  state      <= ST_WAIT;
               end else begin
                  idx       <= idx + 3'd1;
                  onfi_wen  <= 1'b0;
                  onfi_dq_o <= addr_byte(addr_q, idx + 3'd1);
                  state     <= ST_ADDR_LO;
               end
            end
            ST_WAIT: begin
               if (cnt == CNT_W'(TWHR_CYC - 1)) begin
                  cnt     <= '0;
                  data_ph <= 1'b1;
                  state   <= ST_DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_DATA: begin
               if (owner_rel) begin
                  done[owner] <= 1'b1;
                  gnt         <= 2'b00;
                  data_ph     <= 1'b0;
                  onfi_cen    <= 1'b1;
                  state       <= ST_IDLE;
               end
`ifdef ONFI_SEQ_TIMEOUT_EN
               else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                  err      <= 1'b1;
                  gnt      <= 2'b00;
                  data_ph  <= 1'b0;
                  onfi_cen <= 1'b1;
                  state    <= ST_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
`endif
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
